ifetch_unit: RTL

- Instruction fetch stage directly upstream of the control decoder in the rv32i_sc core.
- Owns the PC register and runs a request/response handshake with instruction memory.
- Holds the fetched instruction stable and presents opcode/func3/func7 to the decoder.
- Advances the PC on retire to PC+4, or to the redirect target when the decoder's branch output is high.

---
 rtl/ifetch_unit.sv | 81 ++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner and imem request/response fetch stage feeding the decoder
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic [31:0] retired,
    output logic        misalign_err,
    output logic        fetch_err
);
    typedef enum logic [2:0] {RST_WAIT, FETCH, WAIT, ISSUE, ERROR} state_t;
    state_t state, state_nxt;
    logic [7:0] cnt;
    logic retire, got, timeout;
    assign imem_req  = state == FETCH;
    assign imem_addr = pc;
    assign pc_plus_4 = pc + 32'd4;
    assign opcode    = instr[6:0];
    assign func3     = instr[14:12];
    assign func7     = instr[31:25];
    // state register, reset forces a clean restart from RST_WAIT
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= RST_WAIT;
        else     state <= state_nxt;
    // next state plus the single-cycle events that steer the datapath
    always_comb begin
        state_nxt = state;
        got       = state == WAIT && imem_rvalid;
        timeout   = state == WAIT && !imem_rvalid && cnt == 8'(TIMEOUT - 1);
        retire    = state == ISSUE && !stall;
        case (state)
            RST_WAIT: state_nxt = FETCH;
            FETCH:    state_nxt = WAIT;
            WAIT:     state_nxt = got ? ISSUE : timeout ? ERROR : WAIT;
            ISSUE:    state_nxt = retire ? FETCH : ISSUE;
            default:  state_nxt = ERROR;
        endcase
    end
    // PC, held instruction, wait counter, retire count and error flags
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc           <= RESET_PC;
            instr        <= NOP_INSTR;
            instr_valid  <= 1'b0;
            retired      <= 32'd0;
            misalign_err <= 1'b0;
            fetch_err    <= 1'b0;
            cnt          <= 8'd0;
        end else begin
            misalign_err <= retire && branch && |branch_target[1:0];
            if (state == FETCH) cnt <= 8'd0;
            else if (state == WAIT && !imem_rvalid) cnt <= cnt + 8'd1;
            if (timeout) fetch_err <= 1'b1;
            if (got) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                retired     <= retired + 32'd1;
                pc          <= branch ? {branch_target[31:2], 2'b00} : pc + 32'd4;
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
endmodule
